// File: rtl/bcd_display_seq_if.sv
// Request/result bundle for bcd_display_seq: binary request in, status and
// active-low seven-segment digit patterns out.
interface bcd_display_seq_if #(
  parameter int BIN_W = 32
);
  logic             start;
  logic [BIN_W-1:0] binary;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [6:0]       ones;
  logic [6:0]       tens;
  logic [6:0]       hundreds;
  logic [6:0]       thousands;

  modport master (
    output start, binary,
    input  busy, done, overflow, ones, tens, hundreds, thousands
  );

  modport slave (
    input  start, binary,
    output busy, done, overflow, ones, tens, hundreds, thousands
  );
endinterface

// File: rtl/bcd_display_seq.sv
// Sequential binary-to-4-digit seven-segment converter (double dabble, clamped at 9999).
// Option: define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros on the upper three digits.
module bcd_display_seq #(
  parameter int BIN_W       = 32,
  parameter int CONV_CYCLES = 14
) (
  input  logic             clk,
  input  logic             n_reset,
  bcd_display_seq_if.slave bus
);
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        acc_q, acc_d;
  logic [13:0]        src_q, src_d;
  logic [15:0]        digits_q, digits_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               too_big;
  logic [15:0]        adj;
  logic [3:0]         blank;
  logic [6:0]         seg [4];

  // Only the magnitude compare looks at the upper bits; the datapath is 14 bits.
  assign too_big = (bus.binary > BIN_W'(9999));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                        : acc_q[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      src_q    <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      src_q    <= src_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(CONV_CYCLES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    src_d    = src_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    busy_d   = (state_d == CONVERT);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          acc_d = '0;
          src_d = too_big ? 14'd9999 : bus.binary[13:0];
          ovf_d = too_big;
        end
      end
      CONVERT: begin
        acc_d = {adj[14:0], src_q[13]};
        src_d = {src_q[12:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: begin
        digits_d = acc_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // A digit blanks only while it and every digit above it are zero.
  assign blank[3] = (digits_q[15:12] == 4'd0);
  assign blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
  assign blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
  assign blank[0] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  generate
    for (gi = 0; gi < 4; gi++) begin : g_seg
      assign seg[gi] = blank[gi] ? 7'h7F : seg7(digits_q[gi*4 +: 4]);
    end
  endgenerate

  assign bus.ones      = seg[0];
  assign bus.tens      = seg[1];
  assign bus.hundreds  = seg[2];
  assign bus.thousands = seg[3];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bcd_display_seq.sv
// Scoreboard bench for bcd_display_seq: directed starts push expected displays,
// a negedge monitor pops and checks on every done pulse.
module tb_bcd_display_seq;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct {
    logic [28:0] val;   // {overflow, thousands, hundreds, tens, ones}
    int          cyc;
  } exp_t;
  exp_t sb[$];

  bcd_display_seq_if #(.BIN_W(32)) bus ();

  bcd_display_seq #(.BIN_W(32), .CONV_CYCLES(14)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [28:0] pack(input logic ovf, input logic [6:0] th,
                                       input logic [6:0] hu, input logic [6:0] te,
                                       input logic [6:0] on);
    return {ovf, th, hu, te, on};
  endfunction

  // Monitor: every done pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (n_reset && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_latency", 32'(cyc), 32'(e.cyc));
        check("display", 32'({bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.ones}),
              32'(e.val));
        $display("done at cycle %0d: ovf=%0b segs=%h %h %h %h", cyc, bus.overflow,
                 bus.thousands, bus.hundreds, bus.tens, bus.ones);
      end
    end
  end

  // Caller is at a negedge; the start is accepted on the following posedge.
  task automatic issue(input logic [31:0] v, input logic [28:0] exp_val);
    exp_t e;
    bus.start  = 1'b1;
    bus.binary = v;
    e.val = exp_val;
    e.cyc = cyc + 1 + 15;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [31:0] v, input logic [28:0] exp_val);
    @(negedge clk);
    issue(v, exp_val);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_waiting_done", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int busy_cnt;
    bus.start  = 1'b0;
    bus.binary = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_ones", 32'(bus.ones), 32'h40);
    check("rst_tens", 32'(bus.tens), 32'(LZ));
    check("rst_hundreds", 32'(bus.hundreds), 32'(LZ));
    check("rst_thousands", 32'(bus.thousands), 32'(LZ));
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1234: busy count and display
    pulse(32'd1234, pack(1'b0, 7'h79, 7'h24, 7'h30, 7'h19));
    busy_cnt = 1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!bus.busy) break;
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd14);
    wait_drain(40);

    // Overflow clamp, then cleared by the next start
    pulse(32'd70000, pack(1'b1, 7'h10, 7'h10, 7'h10, 7'h10));
    wait_drain(40);
    check("ovf_held", 32'(bus.overflow), 32'd1);
    pulse(32'd5, pack(1'b0, LZ, LZ, LZ, 7'h12));
    wait_drain(40);

    // Start during CONVERT is ignored
    pulse(32'd42, pack(1'b0, LZ, LZ, 7'h19, 7'h24));
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.binary = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(40);
    repeat (20) @(negedge clk);
    check("no_second_conv_busy", 32'(bus.busy), 32'd0);

    // Reset mid-conversion aborts; first edge after release accepts
    @(negedge clk);
    bus.start  = 1'b1;
    bus.binary = 32'd9999;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_display", 32'({bus.thousands, bus.hundreds, bus.tens, bus.ones}),
          32'({LZ, LZ, LZ, 7'h40}));
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    issue(32'd8, pack(1'b0, LZ, LZ, LZ, 7'h00));
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(40);

    // Start held high: back-to-back, done every 16 clocks
    @(negedge clk);
    bus.start  = 1'b1;
    bus.binary = 32'd10;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.val = pack(1'b0, LZ, LZ, 7'h79, 7'h40);
      e.cyc = cyc + 1 + 15 + 16 * k;
      sb.push_back(e);
    end
    wait_drain(80);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("held_final_busy", 32'(bus.busy), 32'd0);
    check("held_display", 32'({bus.thousands, bus.hundreds, bus.tens, bus.ones}),
          32'({LZ, LZ, 7'h79, 7'h40}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_display_seq.md
BCD_DISPLAY_SEQ -- requirements
Module: bcd_display_seq

Interface
REQ-001 Parameter BIN_W, default 32: width of the binary input word.
REQ-002 Parameter CONV_CYCLES, default 14: double-dabble iteration count, sized to hold the value 9999.
REQ-003 Port clk, input, 1: single clock; all state is on its rising edge.
REQ-004 Port n_reset, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request to convert binary; sampled high only in IDLE.
REQ-006 Port binary, input, BIN_W: unsigned value to display, captured on an accepted start.
REQ-007 Port busy, output, 1: high while a conversion is in progress.
REQ-008 Port done, output, 1: one-cycle pulse when new digits are valid.
REQ-009 Port overflow, output, 1: captured value exceeded 9999; held until the next accepted start.
REQ-010 Ports ones, tens, hundreds, thousands, output, 7 each: active-low seven-segment patterns, bit0=a through bit6=g.

Function
REQ-011 The block SHALL implement FSM states IDLE, CONVERT and DONE.
REQ-012 IDLE: start=1 SHALL capture binary, set busy=1 on the next edge, and go to CONVERT.
REQ-013 Capture: a value greater than 9999 SHALL be replaced by 9999 and set overflow=1; otherwise overflow=0.
REQ-014 CONVERT step: each BCD nibble of 5 or more SHALL have 3 added, then the 16-bit BCD accumulator and the 14-bit source SHALL shift left one bit together.
REQ-015 CONVERT SHALL perform exactly CONV_CYCLES steps (one per clock), counted by an iteration counter, then go to DONE.
REQ-016 DONE SHALL last one cycle.
  - Latches the accumulator into the digit registers.
  - Asserts done=1 and drops busy to 0.
  - Returns to IDLE.
REQ-017 Latency: from the start-accepting edge to the done pulse SHALL be CONV_CYCLES+1 clocks, i.e. 15 at default.
REQ-018 A start during CONVERT or DONE SHALL be ignored, with no queuing and no effect on the current conversion.
REQ-019 Digit outputs SHALL hold the previous result throughout a conversion and change only in DONE.
REQ-020 Segment encoding, hex, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - blank=7F
REQ-021 Segment outputs SHALL be decoded combinationally from the registered digits.
REQ-022 Bits of binary above bit 13 SHALL participate only in the >9999 compare.
REQ-023 If start is held high continuously, a new conversion SHALL begin on the first IDLE cycle after DONE.

Reset
REQ-024 n_reset=0 SHALL, asynchronously:
  - force IDLE and clear the iteration counter;
  - clear the accumulator and all digits to 0;
  - set busy=0, done=0, overflow=0.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the display reverts to the reset pattern.
REQ-026 After reset release, the first start SHALL be accepted on the first rising edge at which n_reset=1.

Configuration
REQ-027 Macro BCD_LEADING_ZERO_BLANK_EN is the single compile-time option.
REQ-028 When BCD_LEADING_ZERO_BLANK_EN is defined:
  - thousands, hundreds and tens SHALL show blank (7F) while they and all higher digits are 0;
  - ones SHALL always show its digit.
REQ-029 When BCD_LEADING_ZERO_BLANK_EN is undefined, all four digits SHALL always show their decoded value, leading zeros included.

Verification
REQ-030 Reset then idle -> busy=0, done=0, overflow=0; without macro ones..thousands=40,40,40,40; with macro ones=40 and the rest 7F.
REQ-031 start=1 one cycle with binary=1234 -> busy for 14 cycles, done on the 15th edge; thousands=79, hundreds=24, tens=30, ones=19; overflow=0.
REQ-032 binary=32'd70000 -> all four digits 10 (9999), overflow=1; next conversion of 5 -> overflow=0; ones=12; others 40 without macro, 7F with macro.
REQ-033 Start 42, then start 7 pulsed during CONVERT -> single done pulse, display 0042 (40,40,19,24), then IDLE with no second conversion.
REQ-034 Start 9999, then n_reset=0 after cycle 6 -> no done pulse, busy=0 immediately; digits at reset pattern; a subsequent start 8 displays 0008 (40,40,40,00).
REQ-035 start held high with binary=10 -> back-to-back conversions with done every 16 clocks; display stable at 0010 (40,40,79,40).
